// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed seven-segment scan controller.
package seg_pkg;

  localparam int DIGIT_W = 8;
  localparam int IDX_W = 3;

  // Anodes are active-low: a 1 switches the digit off.
  localparam logic ANODE_OFF = 1'b1;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg_refresh_prescaler.sv
// Digit-slot prescaler: counts 0..REFRESH_DIV-1 and flags the end of the
// slot and the end of the blanking interval at the start of each slot.
module seg_refresh_prescaler #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic slot_end_o,
  output logic blank_done_o
);

  localparam int CNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Slot end and blank end are decoded straight from the count.
  always_comb begin
    slot_end_o   = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    blank_done_o = (BLANK_CYCLES > 0) && (cnt_q == CNT_W'(BLANK_LAST));
    cnt_d        = slot_end_o ? '0 : cnt_q + CNT_W'(1);
  end

  // Free-running slot counter, wrapping at the slot length.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_controller.sv
// Scan sequencer for a multiplexed seven-segment display: walks the digit
// slots, blanks the anodes at the start of each slot to avoid ghosting, and
// double-buffers digit values so updates land only on frame boundaries.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int N_DIGITS     = 5,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [DIGIT_W-1:0]  wr_data,
  input  logic                commit_req,
  input  logic [N_DIGITS-1:0] en_mask,
  output logic [N_DIGITS-1:0] anode,
  output logic [DIGIT_W-1:0]  digit_data,
  output logic [IDX_W-1:0]    digit_idx,
  output logic                frame_done,
  output logic                wr_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);
  // One extra bit so N_DIGITS = 8 still compares correctly.
  localparam logic [IDX_W:0]   NDIG     = (IDX_W + 1)'(N_DIGITS);

  logic slot_end;
  logic blank_done;
  logic boundary;
  logic commit;
  logic wr_fire;
  logic wr_in_range;

  scan_state_e state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                pending_q, pending_d;
  logic [N_DIGITS-1:0] anode_q, anode_d;
  logic [DIGIT_W-1:0]  data_q, data_d;
  logic                frame_done_q;
  logic                wr_err_q, wr_err_d;

  logic [DIGIT_W-1:0] shadow_q [N_DIGITS];
  logic [DIGIT_W-1:0] active_q [N_DIGITS];

  seg_refresh_prescaler #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_prescaler (
    .clk_i        (clk),
    .reset_i      (reset),
    .slot_end_o   (slot_end),
    .blank_done_o (blank_done)
  );

  // Frame boundary handshake, write acceptance and commit decision.
  always_comb begin
    boundary    = slot_end && (idx_q == LAST_IDX);
    wr_ready    = ~boundary;
    wr_fire     = wr_valid && wr_ready;
    wr_in_range = ({1'b0, wr_idx} < NDIG);
    wr_err_d    = wr_fire && !wr_in_range;
    commit      = boundary && (pending_q || commit_req);
    // Boundary always clears pending: either it commits, or nothing was pending.
    pending_d   = boundary ? 1'b0 : (pending_q || commit_req);
  end

  // Next-state logic for the blank/show FSM and the digit index.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      BLANK: if (blank_done || (BLANK_CYCLES == 0)) state_d = SHOW;
      SHOW:  if (slot_end && (BLANK_CYCLES != 0)) state_d = BLANK;
      default: state_d = BLANK;
    endcase
    if (slot_end) begin
      idx_d = boundary ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Output decode from the current state; registered one cycle later.
  always_comb begin
    anode_d = {N_DIGITS{ANODE_OFF}};
    data_d  = '0;
    if (state_q == SHOW) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (idx_q == IDX_W'(i)) begin
          anode_d[i] = ~en_mask[i];
          data_d     = active_q[i];
        end
      end
    end
  end

  // Control state, scan index and registered display outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= BLANK;
      idx_q        <= '0;
      pending_q    <= 1'b0;
      anode_q      <= {N_DIGITS{ANODE_OFF}};
      data_q       <= '0;
      frame_done_q <= 1'b0;
      wr_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pending_q    <= pending_d;
      anode_q      <= anode_d;
      data_q       <= data_d;
      frame_done_q <= boundary;
      wr_err_q     <= wr_err_d;
    end
  end

  // Shadow takes processor writes; active is refreshed only at a frame boundary.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_DIGITS; i++) begin
        if (wr_fire && (wr_idx == IDX_W'(i))) begin
          shadow_q[i] <= wr_data;
        end
        if (commit) begin
          active_q[i] <= shadow_q[i];
        end
      end
    end
  end

  assign anode      = anode_q;
  assign digit_data = data_q;
  assign digit_idx  = idx_q;
  assign frame_done = frame_done_q;
  assign wr_err     = wr_err_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Directed bench for seg_scan_controller with a short refresh slot
// (10 cycles, 2 blank cycles, 5 digits).
module tb_seg_scan_controller;

  localparam int ND = 5;
  localparam int RD = 10;
  localparam int BC = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [2:0]    wr_idx = 3'd0;
  logic [7:0]    wr_data = 8'd0;
  logic          commit_req = 1'b0;
  logic [ND-1:0] en_mask = 5'b11111;
  logic [ND-1:0] anode;
  logic [7:0]    digit_data;
  logic [2:0]    digit_idx;
  logic          frame_done;
  logic          wr_err;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  // Digit values packed as {d4,d3,d2,d1,d0}.
  localparam logic [39:0] ACT0 = 40'h0;
  localparam logic [39:0] ACT1 = {8'd9, 8'd8, 8'd4, 8'd5, 8'd2};
  localparam logic [39:0] ACT2 = {8'd9, 8'd8, 8'd4, 8'd7, 8'd2};

  seg_scan_controller #(
    .N_DIGITS     (ND),
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_idx     (wr_idx),
    .wr_data    (wr_data),
    .commit_req (commit_req),
    .en_mask    (en_mask),
    .anode      (anode),
    .digit_data (digit_data),
    .digit_idx  (digit_idx),
    .frame_done (frame_done),
    .wr_err     (wr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h", tag, cyc, got, want);
    end
  endtask

  // Reference behaviour: outputs at cycle c reflect the scan position at c-1.
  function automatic logic [ND-1:0] m_anode(input int c, input logic [ND-1:0] en);
    logic [ND-1:0] a;
    int p, idx;
    a = '1;
    if (c > 0) begin
      p   = c - 1;
      idx = (p / RD) % ND;
      if ((p % RD) >= BC) a[idx] = ~en[idx];
    end
    return a;
  endfunction

  function automatic logic [7:0] m_data(input int c, input logic [39:0] act);
    int p, idx;
    if (c == 0) return 8'd0;
    p   = c - 1;
    idx = (p / RD) % ND;
    if ((p % RD) >= BC) return act[idx*8 +: 8];
    return 8'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_cycle(input logic [ND-1:0] en, input logic [39:0] act, input logic err);
    chk("anode",      anode,      m_anode(cyc, en));
    chk("digit_data", digit_data, m_data(cyc, act));
    chk("digit_idx",  digit_idx,  (cyc / RD) % ND);
    chk("frame_done", frame_done, (cyc > 0) && (cyc % (RD * ND) == 0));
    chk("wr_ready",   wr_ready,   (cyc % (RD * ND)) != (RD * ND - 1));
    chk("wr_err",     wr_err,     err);
  endtask

  task automatic run_to(input int last, input logic [ND-1:0] en, input logic [39:0] act);
    while (cyc < last) begin
      tick();
      check_cycle(en, act, 1'b0);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_anode",      anode,      5'b11111);
    chk("rst_digit_data", digit_data, 8'd0);
    chk("rst_digit_idx",  digit_idx,  3'd0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_wr_err",     wr_err,     1'b0);
    chk("rst_wr_ready",   wr_ready,   1'b1);
  endtask

  initial begin
    logic [7:0] vals [5];
    vals[0] = 8'd2; vals[1] = 8'd5; vals[2] = 8'd4; vals[3] = 8'd8; vals[4] = 8'd9;

    // Reset, then two full frames of plain scanning.
    @(posedge clk);
    #1;
    check_reset_vals();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    check_cycle(5'b11111, ACT0, 1'b0);
    run_to(100, 5'b11111, ACT0);

    // Fill the shadow without committing: display stays dark for a frame.
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1'b1;
      wr_idx   = 3'(i);
      wr_data  = vals[i];
      tick();
      check_cycle(5'b11111, ACT0, 1'b0);
    end
    wr_valid = 1'b0;
    run_to(160, 5'b11111, ACT0);

    // Commit request lands at the boundary ending cycle 199.
    commit_req = 1'b1;
    tick();
    check_cycle(5'b11111, ACT0, 1'b0);
    commit_req = 1'b0;
    run_to(200, 5'b11111, ACT0);
    run_to(248, 5'b11111, ACT1);

    // Write held across the boundary cycle plus a coincident commit.
    tick();
    check_cycle(5'b11111, ACT1, 1'b0);
    chk("ready_at_boundary", wr_ready, 1'b0);
    wr_valid   = 1'b1;
    wr_idx     = 3'd1;
    wr_data    = 8'd7;
    commit_req = 1'b1;
    tick();
    check_cycle(5'b11111, ACT1, 1'b0);
    chk("ready_after_boundary", wr_ready, 1'b1);
    commit_req = 1'b0;
    tick();
    check_cycle(5'b11111, ACT1, 1'b0);
    wr_valid = 1'b0;
    // Old shadow was committed and nothing stays pending into the next frame.
    run_to(350, 5'b11111, ACT1);

    // Out-of-range write: error pulse only, no storage.
    wr_valid = 1'b1;
    wr_idx   = 3'd6;
    wr_data  = 8'hAA;
    tick();
    check_cycle(5'b11111, ACT1, 1'b1);
    wr_valid = 1'b0;
    tick();
    check_cycle(5'b11111, ACT1, 1'b0);
    commit_req = 1'b1;
    tick();
    check_cycle(5'b11111, ACT1, 1'b0);
    commit_req = 1'b0;
    run_to(400, 5'b11111, ACT1);

    // Digit 2 masked off for one frame.
    en_mask = 5'b11011;
    run_to(460, 5'b11011, ACT2);
    en_mask = 5'b11111;
    run_to(485, 5'b11111, ACT2);
    chk("slot3_anode", anode, 5'b10111);
    chk("slot3_data",  digit_data, 8'd8);

    // Asynchronous reset in the middle of slot 3 SHOW.
    #1;
    reset = 1'b1;
    #1;
    check_reset_vals();
    @(posedge clk);
    #1;
    check_reset_vals();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
    check_cycle(5'b11111, ACT0, 1'b0);

    // Committing right after reset must show a cleared shadow.
    commit_req = 1'b1;
    tick();
    check_cycle(5'b11111, ACT0, 1'b0);
    commit_req = 1'b0;
    run_to(70, 5'b11111, ACT0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Scan sequencer for the 5-digit multiplexed seven-segment display driven by the 8-bit RISC processor.
- Owns the refresh prescaler, the digit-select state machine and the blanking (anti-ghosting) interval.
- Double-buffers digit values: the processor writes over a valid/ready port, and writes are committed only at frame boundaries, so the display never tears.
- Output per-digit data byte and active-low anodes feed the segment decode/drive stage.

Parameters:
- N_DIGITS, 5, number of multiplexed digits (2..8).
- REFRESH_DIV, 100000, clock cycles per digit slot (1 ms at 100 MHz).
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  processor write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_idx  in  3  target digit index.
- wr_data  in  8  digit value (binary/hex nibble or raw pattern, passed through).
- commit_req  in  1  pulse: copy shadow to active at the next frame boundary.
- en_mask  in  N_DIGITS  per-digit enable; 0 keeps that digit's anode off.
- anode  out  N_DIGITS  active-low digit enables, registered.
- digit_data  out  8  active value of the current digit, registered.
- digit_idx  out  3  current scan index, registered.
- frame_done  out  1  one-cycle pulse at end of last digit slot.
- wr_err  out  1  one-cycle pulse when an accepted write has wr_idx >= N_DIGITS.

Behaviour:
- Reset values (async, immediate, including mid-frame):
  - cnt = 0, digit_idx = 0, state = BLANK.
  - anode = all 1s, digit_data = 0.
  - shadow[] = 0, active[] = 0, pending = 0.
  - frame_done = 0, wr_err = 0.
- Prescaler cnt counts 0..REFRESH_DIV-1 and wraps to 0. slot_end = (cnt == REFRESH_DIV-1).
- FSM states:
  - BLANK: entered at cnt = 0. Drives anode = all 1s and digit_data = 0.
  - SHOW: entered when cnt == BLANK_CYCLES-1 completes, i.e. outputs show from cnt = BLANK_CYCLES. Drives anode[digit_idx] = ~en_mask[digit_idx] (others 1) and digit_data = active[digit_idx].
  - SHOW -> BLANK on slot_end.
  - BLANK_CYCLES = 0 means the FSM never enters BLANK.
- Outputs are registered and reflect the state of the previous cycle's decision. There is one cycle of latency from the cnt boundary to the anode change.
- On slot_end, digit_idx increments. At N_DIGITS-1 it wraps to 0, and this wrap cycle is the frame boundary (boundary = slot_end && digit_idx == N_DIGITS-1).
- frame_done is asserted in the cycle after the boundary, for 1 cycle.
- Write port:
  - wr_ready = ~boundary (combinational). It is low for exactly one cycle per frame.
  - An accepted write sets shadow[wr_idx] <= wr_data.
  - If wr_idx >= N_DIGITS, the write is accepted, no register changes, and wr_err pulses the next cycle.
  - Back-to-back writes are accepted every cycle. A later write to the same index overwrites the earlier one.
- Commit:
  - commit_req sets pending.
  - At a boundary with (pending || commit_req): active <= shadow and pending <= 0.
  - commit_req coincident with the boundary is applied at that boundary.
  - commit_req while already pending has no extra effect.
  - Writes in the same cycle as a boundary are impossible, because wr_ready is low.
- Changes to en_mask take effect at the next registered output update (1 cycle). They are not frame-aligned.
- digit_data is a pure pass-through of the stored byte; segment decoding is downstream.
- Widths: cnt is $clog2(REFRESH_DIV) bits. digit_idx is 3 bits, with its upper values unused when N_DIGITS < 8.

Decomposition:
- Shared package seg_pkg holds:
  - DIGIT_W = 8.
  - IDX_W = 3.
  - ANODE_OFF = 1'b1.
  - the scan state encoding typedef (BLANK = 0, SHOW = 1).
- One natural sub-module, seg_refresh_prescaler. It contains cnt and generates slot_end and blank_done; the controller instantiates it.
- Shadow/active buffers and the FSM stay in the top module.

Test Plan (REFRESH_DIV = 10, BLANK_CYCLES = 2, N_DIGITS = 5, en_mask = 5'b11111):
- Reset then run:
  - anode = 5'b11111 during reset and for cycles 0-2.
  - anode = 5'b11110 for slot-0 SHOW cycles.
  - digit_idx walks 0,1,2,3,4,0.
  - frame_done pulses once every 50 cycles.
- Write digits 2,5,4,8,9 to idx 0..4, with no commit:
  - digit_data stays 0 for a full frame.
  - Pulse commit_req, then at the next frame the SHOW slots output 2,5,4,8,9 in order.
- Write and boundary collision:
  - Hold wr_valid with idx 1, data 7 across the boundary cycle. wr_ready = 0 for exactly that cycle, and the write is accepted on the following cycle.
  - commit_req on the same boundary cycle commits the old shadow, not 7.
- Out-of-range write:
  - wr_idx = 6, data 0xAA. wr_err pulses 1 cycle, and shadow and the display are unchanged after commit.
- en_mask = 5'b11011:
  - During slot 2 SHOW, anode = 5'b11111.
  - The other slots drive their normal one-hot-low pattern.
- Assert reset mid-SHOW of slot 3:
  - anode goes to 5'b11111 asynchronously (before the next clk edge).
  - digit_data = 0, and active and shadow are cleared.
  - After release the scan restarts at digit_idx 0 in BLANK.
